// File: rtl/window3x3_pkg.sv
// Shared types and constants for the 3x3 window generator.
// Optional position outputs are enabled with WINDOW3X3_POS_EN.
package window3x3_pkg;
    localparam int PIX_W_DEF = 8;

    typedef logic [8:0][PIX_W_DEF-1:0] win3x3_t;

    typedef enum logic {FILL, RUN} state_t;

    // Row-major window positions, oldest line first
    localparam int TL = 0, TM = 1, TR = 2;
    localparam int ML = 3, MM = 4, MR = 5;
    localparam int BL = 6, BM = 7, BR = 8;
endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out stream bundle for window3x3_gen.
// m_row/m_col exist only when WINDOW3X3_POS_EN is defined.
interface window3x3_gen_if #(parameter int PIX_W = 8);
    logic               s_valid;
    logic               s_ready;
    logic               s_sof;
    logic [PIX_W-1:0]   s_pixel;
    logic               m_valid;
    logic               m_ready;
    logic [9*PIX_W-1:0] m_window;
    logic               frame_done;
`ifdef WINDOW3X3_POS_EN
    logic [15:0]        m_row;
    logic [15:0]        m_col;
`endif

    modport slave (
        input  s_valid, s_sof, s_pixel, m_ready,
        output s_ready, m_valid, m_window, frame_done
`ifdef WINDOW3X3_POS_EN
        , output m_row, m_col
`endif
    );

    modport master (
        output s_valid, s_sof, s_pixel, m_ready,
        input  s_ready, m_valid, m_window, frame_done
`ifdef WINDOW3X3_POS_EN
        , input m_row, m_col
`endif
    );
endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// Single-port line memory: combinational read of the addressed word,
// write lands at the clock edge, so a same-cycle read sees the old data.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end
endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two buffered lines plus a 3x3 shift
// array; one window per interior pixel. Position outputs with WINDOW3X3_POS_EN.
module window3x3_gen
    import window3x3_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    window3x3_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d, col_e;
    logic [RW-1:0]         row_q, row_d, row_e;
    logic [8:0][PIX_W-1:0] win_q, win_d, mwin_q;
    logic                  mvld_q, mvld_d, done_q, done_d;
    logic                  accept, produce, last_px;
    logic [2*PIX_W-1:0]    lb_rd;

    assign bus.s_ready = !mvld_q || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;

    // A start-of-frame pixel is (0,0) regardless of where the counters are
    assign col_e   = bus.s_sof ? '0 : col_q;
    assign row_e   = bus.s_sof ? '0 : row_q;
    assign last_px = (col_e == COL_LAST) && (row_e == ROW_LAST);
    assign produce = accept && (state_q == RUN) && !bus.s_sof && (col_e >= CW'(2));

    // {line-2, line-1} stored per column; shifted up one line on every write
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(2*PIX_W)) u_lb (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (col_e),
        .wdata_i ({lb_rd[PIX_W-1:0], bus.s_pixel}),
        .rdata_o (lb_rd)
    );

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        state_d = state_q;
        win_d   = win_q;
        done_d  = 1'b0;
        if (accept) begin
            win_d[TL] = win_q[TM];
            win_d[TM] = win_q[TR];
            win_d[TR] = lb_rd[2*PIX_W-1:PIX_W];
            win_d[ML] = win_q[MM];
            win_d[MM] = win_q[MR];
            win_d[MR] = lb_rd[PIX_W-1:0];
            win_d[BL] = win_q[BM];
            win_d[BM] = win_q[BR];
            win_d[BR] = bus.s_pixel;
            done_d    = last_px;
            if (col_e == COL_LAST) begin
                col_d = '0;
                row_d = (row_e == ROW_LAST) ? '0 : row_e + RW'(1);
            end else begin
                col_d = col_e + CW'(1);
                row_d = row_e;
            end
            if (bus.s_sof || last_px)
                state_d = FILL;
            else if ((row_e == RW'(1)) && (col_e == COL_LAST))
                state_d = RUN;
        end
    end

    always_comb begin
        mvld_d = mvld_q;
        if (produce)          mvld_d = 1'b1;
        else if (bus.m_ready) mvld_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            mwin_q  <= '0;
            mvld_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            mvld_q  <= mvld_d;
            done_q  <= done_d;
            if (produce) mwin_q <= win_d;
        end
    end

    assign bus.m_valid    = mvld_q;
    assign bus.m_window   = mwin_q;
    assign bus.frame_done = done_q;

`ifdef WINDOW3X3_POS_EN
    logic [15:0] mrow_q, mcol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mrow_q <= '0;
            mcol_q <= '0;
        end else if (produce) begin
            mrow_q <= 16'(row_e) - 16'd1;
            mcol_q <= 16'(col_e) - 16'd1;
        end
    end

    assign bus.m_row = mrow_q;
    assign bus.m_col = mcol_q;
`endif
endmodule

// File: tb/tb_window3x3_gen.sv
// Self-checking bench for window3x3_gen on a 5x4 frame: directed table plus
// randomized traffic scored against a frame-array reference model.
module tb_window3x3_gen;
  import window3x3_pkg::*;

  localparam int W = 5, H = 4, PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  window3x3_gen_if #(.PIX_W(PW)) bus();

  window3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int      br_r;   // input position of the bottom-right pixel
    int      br_c;
    win3x3_t win;    // expected window for pixel = row*16+col
  } vec_t;
  vec_t tbl[6];

  int total = 0, passed = 0;
  int fr[H][W];
  int pos = 0;
  bit done_exp = 0;
  int nwin = 0, done_cnt = 0;
  win3x3_t expq[$], got[$];
  int exprq[$], expcq[$], gotr[$], gotc[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic win3x3_t mkwin(int r, int c);
    win3x3_t w;
    for (int k = 0; k < 9; k++) w[k] = 8'(fr[r-2+k/3][c-2+k%3]);
    return w;
  endfunction

  task automatic model_clear();
    pos = 0; done_exp = 0;
    expq.delete(); exprq.delete(); expcq.delete();
  endtask

  task automatic cycle(input bit v, input bit sof, input logic [7:0] pix, input bit mr, output bit acc);
    int r, c;
    @(negedge clk);
    chk("frame_done", bus.frame_done, done_exp);
    if (bus.frame_done) done_cnt++;
    done_exp = 0;
    bus.s_valid = v; bus.s_sof = sof; bus.s_pixel = pix; bus.m_ready = mr;
    #1;
    chk("m_valid", bus.m_valid, expq.size() != 0);
    chk("s_ready", bus.s_ready, (expq.size() == 0) || mr);
    if (bus.m_valid && mr) begin
      got.push_back(bus.m_window); nwin++;
`ifdef WINDOW3X3_POS_EN
      gotr.push_back(int'(bus.m_row)); gotc.push_back(int'(bus.m_col));
`endif
      if (expq.size() != 0) begin
        chk("window", bus.m_window, expq.pop_front());
`ifdef WINDOW3X3_POS_EN
        chk("m_row", bus.m_row, exprq.pop_front());
        chk("m_col", bus.m_col, expcq.pop_front());
`endif
      end
    end
    acc = v && bus.s_ready;
    if (acc) begin
      if (sof) pos = 0;
      r = pos / W; c = pos % W;
      fr[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        expq.push_back(mkwin(r, c)); exprq.push_back(r-1); expcq.push_back(c-1);
      end
      if (pos == W*H-1) done_exp = 1;
      pos = (pos + 1) % (W*H);
    end
  endtask

  task automatic feed(input logic [7:0] pix, input bit sof);
    bit a = 0;
    int n = 0;
    do begin cycle(1'b1, sof, pix, 1'b1, a); n++; end while (!a && n < 50);
    if (!a) begin total++; $display("FAIL feed_timeout: got no accept expected accept"); end
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.s_valid = 1'b0; bus.s_sof = 1'b0; bus.m_ready = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    chk("rst_m_window", bus.m_window, 72'h0);
`ifdef WINDOW3X3_POS_EN
    chk("rst_m_row", bus.m_row, 16'h0);
    chk("rst_m_col", bus.m_col, 16'h0);
`endif
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic start_test();
    got.delete(); gotr.delete(); gotc.delete(); nwin = 0; done_cnt = 0;
  endtask

  task automatic check_table(input string nm, input int base);
    chk({nm, "_count"}, got.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk({nm, "_win"}, (base + i < got.size()) ? got[base+i] : 72'h0, tbl[i].win);
`ifdef WINDOW3X3_POS_EN
      chk({nm, "_row"}, (base + i < gotr.size()) ? gotr[base+i] : -1, tbl[i].br_r - 1);
      chk({nm, "_col"}, (base + i < gotc.size()) ? gotc[base+i] : -1, tbl[i].br_c - 1);
`endif
    end
  endtask

  function automatic logic [7:0] inc(int r, int c);
    return 8'(r*16 + c);
  endfunction

  initial begin
    bit a;
    tbl[0] = '{2, 2, 72'h22_21_20_12_11_10_02_01_00};
    tbl[1] = '{2, 3, 72'h23_22_21_13_12_11_03_02_01};
    tbl[2] = '{2, 4, 72'h24_23_22_14_13_12_04_03_02};
    tbl[3] = '{3, 2, 72'h32_31_30_22_21_20_12_11_10};
    tbl[4] = '{3, 3, 72'h33_32_31_23_22_21_13_12_11};
    tbl[5] = '{3, 4, 72'h34_33_32_24_23_22_14_13_12};
    bus.s_valid = 0; bus.s_sof = 0; bus.s_pixel = 0; bus.m_ready = 0;
    do_reset();

    // increasing 5x4 frame, no backpressure
    start_test();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) feed(inc(r, c), r == 0 && c == 0);
    idle(3);
    check_table("inc", 0);
    chk("inc_done_pulses", done_cnt, 1);

    // backpressure on the first window
    start_test();
    for (int p = 0; p <= 12; p++) feed(inc(p / W, p % W), p == 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, inc(2, 3), 1'b0, a);
      chk("bp_no_accept", a, 1'b0);
      chk("bp_hold", bus.m_window, tbl[0].win);
    end
    for (int p = 13; p < W*H; p++) feed(inc(p / W, p % W), 1'b0);
    idle(3);
    check_table("bp", 0);

    // back-to-back frames, second frame built only from its own pixels
    start_test();
    for (int p = 0; p < W*H; p++) feed(8'(8'h80 + p*3), p == 0);
    for (int p = 0; p < W*H; p++) feed(inc(p / W, p % W), p == 0);
    idle(3);
    check_table("b2b", 6);
    chk("b2b_done_pulses", done_cnt, 2);

    // resync: s_sof arrives at (1,3)
    start_test();
    for (int p = 0; p < 8; p++) feed(8'(8'h40 + p), p == 0);
    for (int p = 0; p < W*H; p++) begin
      feed(inc(p / W, p % W), p == 0);
      if (p == 11) chk("sof_no_early_window", nwin, 0);
    end
    idle(3);
    check_table("sof", 0);

    // reset at (2,3) with a window pending
    start_test();
    for (int p = 0; p <= 12; p++) feed(8'(8'hC0 + p), p == 0);
    do_reset();
    start_test();
    for (int p = 0; p < W*H; p++) feed(inc(p / W, p % W), 1'b0);
    idle(3);
    check_table("rst", 0);

    // randomized traffic against the frame model
    begin
      int idx = 0, frames = 0;
      bit v, sof, mr;
      start_test();
      for (int n = 0; n < 4000 && frames < 8; n++) begin
        v   = $urandom_range(0, 3) != 0;
        sof = (idx == 0 && $urandom_range(0, 1) == 1) || ($urandom_range(0, 60) == 0);
        mr  = $urandom_range(0, 2) != 0;
        cycle(v, sof, 8'($urandom), mr, a);
        if (a) begin
          idx = sof ? 1 : idx + 1;
          if (idx == W*H) begin idx = 0; frames++; end
        end
      end
      idle(4);
      chk("rand_frames", frames, 8);
      chk("rand_drained", expq.size(), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3x3 neighbourhood generator feeding the Sobel edge filter. Accepts a raster-order pixel stream, one pixel per handshake. Buffers the two previous image lines and emits, for every interior pixel, the nine-pixel window in the `Pixels[8:0]` ordering the filter consumes. Sits between the camera/frame source and the Sobel stage.

## Interface
Parameters:
- `IMG_WIDTH`, default 640: pixels per line; must be ≥3.
- `IMG_HEIGHT`, default 480: lines per frame; must be ≥3.
- `PIX_W`, default 8: bits per pixel.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `s_valid` in 1: input pixel valid.
- `s_ready` out 1: input can be accepted.
- `s_sof` in 1: accepted pixel is frame pixel (0,0).
- `s_pixel` in PIX_W: input pixel.
- `m_valid` out 1: window valid.
- `m_ready` in 1: downstream accepts the window.
- `m_window` out 9×PIX_W: window; element k occupies bits [k*PIX_W +: PIX_W].
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Accept a pixel when `s_valid && s_ready`. `s_ready = !m_valid || m_ready` (combinational; no bubble).
- The `row` counter runs 0..IMG_HEIGHT-1 and the `col` counter runs 0..IMG_WIDTH-1.
  - `col` advances on each accept.
  - At `col == IMG_WIDTH-1`, `col` wraps to 0 and `row` advances.
  - At the last pixel, both wrap to 0 and `frame_done` pulses.
- An accepted `s_sof` forces the pixel to be treated as (0,0), whatever the counters hold. The counters continue from (0,1).
- Line buffer, depth IMG_WIDTH, 2×PIX_W wide:
  - Address = `col`.
  - Read-before-write in the accept cycle: read {line-2, line-1} at `col`, then write {line-1, s_pixel}.
- Window registers form a 3×3 shift array, shifted left on each accept.
  - New right column = {line-2, line-1, s_pixel}.
  - Element order, row-major with oldest line first:
    - 0..2: line row-2, cols col-2..col.
    - 3..5: line row-1.
    - 6..8: current line.
- FSM:
  - FILL: `row` < 2; no output.
  - RUN: `row` ≥ 2.
  - FILL→RUN on the accept that wraps `row` 1→2.
  - RUN→FILL on the accept of the frame's last pixel, or on an accepted `s_sof`.
- In RUN, an accept with `col` ≥ 2 produces a window centred at (row-1, col-1).
  - Windows per frame = (IMG_WIDTH-2)×(IMG_HEIGHT-2).
  - Windows are not produced at `col` 0 or 1, so stale shift contents are never emitted.
- Output register:
  - On a producing accept: `m_window` is loaded and `m_valid` is set to 1.
  - Else if `m_ready`: `m_valid` is cleared to 0.
  - `m_window` is held stable while `m_valid && !m_ready`.
- Simultaneous `m_ready` and a producing accept: `m_valid` stays 1 and the new window is loaded.

## Timing
- Reset values:
  - `m_valid` = 0, `m_window` = 0, `frame_done` = 0.
  - `s_ready` = 1.
  - Counters and window registers = 0; FSM = FILL.
- Line-buffer contents are not reset.
- Latency: the window appears on the cycle after the accept of its bottom-right pixel.
- Throughput: 1 window per cycle with `m_ready` held high.
- `frame_done` is asserted the cycle after the last accept.
- Reset mid-frame: outputs return to reset values immediately. The next accepted pixel is (0,0) with or without `s_sof`.

## Configuration
- `WINDOW3X3_POS_EN` defined: adds outputs `m_row` and `m_col`, each 16 bits, giving the window centre (row-1, col-1). They are registered with `m_window` and reset to 0.
- `WINDOW3X3_POS_EN` undefined: the ports and registers are absent; behaviour is otherwise identical.

## Structure
- Package `window3x3_pkg` holds:
  - the default `PIX_W`;
  - the typedef `win3x3_t` (9 elements of PIX_W bits);
  - the FSM enum {FILL, RUN};
  - window-index constants (TL=0 … BR=8).
- One sub-module, `line_buffer`: single-port, read-before-write, parameterised by depth and width, instantiated once at 2×PIX_W width.

## Test plan
- **5×4 frame, increasing values.** Set IMG_WIDTH=5, IMG_HEIGHT=4, pixel = row*16+col, `m_ready`=1.
  - Exactly 6 windows are produced.
  - First window = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22}.
  - Last window = {0x12,0x13,0x14,0x22,0x23,0x24,0x32,0x33,0x34}.
  - `frame_done` pulses once.
- **Backpressure.** Hold `m_ready`=0 when the first window is valid.
  - `s_ready` goes 0 and `m_window` stays unchanged.
  - Release `m_ready`: the remaining windows complete in order with none lost.
- **Two back-to-back frames.** The second frame's windows are built only from second-frame pixels; its first window uses 0x00..0x22 values from frame 2.
- **Resync with `s_sof`.** Assert `s_sof` at (1,3) of frame 1.
  - No window is emitted until row 2 col 2 of the new frame.
  - The window count is 6.
- **Reset mid-frame.** Assert `rst` at (2,3).
  - `m_valid`=0 and `s_ready`=1 immediately.
  - The next full frame yields 6 correct windows.
- **`WINDOW3X3_POS_EN` build.** `m_row`/`m_col` sequence = (1,1),(1,2),(1,3),(2,1),(2,2),(2,3).
